// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: majority-vote bit sampling, parity and
// framing checks, and a single-word valid/ready holding register.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int BAUD_RATE   = 9600,
    parameter int SYS_CLK     = 100_000_000,
    parameter int STOP_BITS   = 1,
    parameter int HAS_PARITY  = 1,
    parameter int PARITY_EVEN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sig,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int DIV = (SYS_CLK + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                 sync1_q, sync2_q, prev_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        div_q, div_d;
    logic [3:0]           tcnt_q, tcnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, pe_out_q, pe_out_d, fe_out_q, fe_out_d;
    logic                 ovr_q, ovr_d;

    logic tick, fall, maj, bit_mid, bit_end, exp_par;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        fall    = prev_q & ~sync2_q;
        // Samples from ticks 7 and 8 are stored; tick 9 uses the live sample.
        maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
        bit_mid = tick && (tcnt_q == 4'd9);
        bit_end = tick && (tcnt_q == 4'd15);
        exp_par = (PARITY_EVEN != 0) ? ^shift_q : ~^shift_q;

        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;

        if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
            if (tcnt_q == 4'd7) smp_d[0] = sync2_q;
            if (tcnt_q == 4'd8) smp_d[1] = sync2_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    div_d   = '0;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_mid && maj)  state_d = S_IDLE;
                else if (bit_end)    state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bcnt_q == DATA_LAST) begin
                        bcnt_d  = '0;
                        state_d = (HAS_PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_mid && (maj != exp_par)) perr_d = 1'b1;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_mid) begin
                    if (!maj) ferr_d = 1'b1;
                    // Leave at mid-bit of the last stop bit to catch a back-to-back start edge.
                    if (bcnt_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (bit_end) bcnt_d = bcnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        data_d   = data_q;
        valid_d  = valid_q;
        pe_out_d = pe_out_q;
        fe_out_d = fe_out_q;
        ovr_d    = 1'b0;
        if (valid_q && ready) valid_d = 1'b0;
        if (done_q) begin
            if (!valid_q || ready) begin
                data_d   = shift_q;
                pe_out_d = perr_q;
                fe_out_d = ferr_q;
                valid_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            state_q  <= S_IDLE;
            div_q    <= '0;
            tcnt_q   <= '0;
            bcnt_q   <= '0;
            smp_q    <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            pe_out_q <= 1'b0;
            fe_out_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= sig;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            bcnt_q   <= bcnt_d;
            smp_q    <= smp_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            done_q   <= done_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            pe_out_q <= pe_out_d;
            fe_out_q <= fe_out_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = pe_out_q;
    assign frame_err  = fe_out_q;
    assign overrun    = ovr_q;
endmodule
